mitm_inject_sequencer: RTL and testbench
========================================

Name: mitm_inject_sequencer

Overview:
- Controller for one direction of the fake bus path, placed between the MITM mode selection and one fake interface of the bus interface block.
- Captures bytes received on the real interface and transforms them according to the active MITM mode.
- Queues the transformed bytes in a small FIFO and sequences the fake transmitter through its ready/start/done handshake.
- Holds keep-alive while a burst is in progress; one instance is used per direction (if0 to if1, if1 to if0).

Parameters:
- NUM_DATA_BITS, 8, width of one bus word.
- NUM_MITM_MODES, 3, width of the one-hot mode_select vector.
- FIFO_DEPTH, 4, queued words; must be a power of 2, at least 2.
- MATCH_VALUE, 8'h55, word that triggers substitution in mode 1.
- REPLACE_VALUE, 8'hAA, substitute word for mode 1.

Ports:
- sys_clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- mode_select  in  NUM_MITM_MODES  one-hot mode request from the I/O handler.
- recv_new_data  in  1  one-cycle pulse: real interface delivered a word.
- real_recv_data  in  NUM_DATA_BITS  received word, valid while recv_new_data is high.
- fake_send_ready  in  1  fake transmitter is idle and can accept a start.
- fake_send_done  in  1  one-cycle pulse: fake transmitter finished the current word.
- fake_select  out  1  1 = bus drives the output line from the fake transmitter; 0 = real pass-through.
- fake_send_start  out  1  one-cycle start pulse to the fake transmitter.
- fake_keep_alive  out  1  keep the fake transaction open between words (SPI SS held, UART line idle-high).
- fake_send_data  out  NUM_DATA_BITS  word being sent.
- overflow  out  1  one-cycle pulse: an incoming word was dropped because the FIFO was full.

Behaviour:
- Reset: all outputs 0; FIFO empty; state IDLE; active_mode = pass-through. Reset asserted mid-transfer aborts immediately: FIFO flushed, start/keep_alive deasserted.
- Mode decode:
  - mode_select == 3'b001 or any non-one-hot value: mode 0, pass-through.
  - 3'b010: mode 1, substitute — a word equal to MATCH_VALUE is queued as REPLACE_VALUE; other words are queued unchanged.
  - 3'b100: mode 2, invert — every word is queued as ~word.
- Mode latching: active_mode is updated from mode_select only when state is IDLE and the FIFO is empty. A change requested mid-burst takes effect after the burst drains.
- fake_select is registered: 1 when active_mode != 0.
- In mode 0:
  - recv_new_data is ignored; nothing is written to the FIFO.
  - fake_send_start and fake_keep_alive stay 0.
- FIFO write (modes 1 and 2):
  - On a recv_new_data cycle, the transformed word is written at the same clock edge.
  - If the FIFO is full and no pop happens in that cycle, the word is dropped and overflow pulses on the next cycle.
  - A simultaneous push and pop while full is accepted, with no overflow.
  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; a separate occupancy count runs 0..FIFO_DEPTH.
- State machine:
  - IDLE: if the FIFO is non-empty and fake_send_ready=1, then:
    - load fake_send_data from the FIFO head;
    - pulse fake_send_start for one cycle;
    - go to WAIT_DONE.
  - WAIT_DONE:
    - fake_send_data is held stable;
    - on fake_send_done, pop the FIFO head and go to IDLE.
    - fake_send_start is not re-asserted in this state.
  - A fake_send_done pulse arriving in IDLE is ignored.
  - fake_send_ready is not sampled in WAIT_DONE.
- Latency: recv_new_data in cycle n (FIFO empty, IDLE, ready=1) gives fake_send_start high in cycle n+2 and fake_send_data valid from cycle n+2.
- keep_alive:
  - fake_keep_alive is registered.
  - It is 1 from the cycle of fake_send_start until, after a fake_send_done, the FIFO is empty and no push occurred that cycle.
  - It drops one cycle after the final done, so back-to-back queued words stay in one SPI transaction.

Test Plan:
- Mode 0 (001), send 3 words via recv_new_data -> fake_select=0, no fake_send_start, FIFO count stays 0.
- Mode 1 (010), receive 8'h55 then 8'h12 with ready=1 and done returned 10 cycles after each start -> sent sequence 8'hAA, 8'h12; first start exactly 2 cycles after the first recv pulse; keep_alive continuous across both words, low 1 cycle after the second done.
- Mode 2 (100), receive 8'h0F -> fake_send_data=8'hF0, one start pulse, data stable until done.
- Mode 1, hold done low, push 6 words -> 4 sent in order; overflow pulses on the 5th and 6th pushes; push on the same cycle as a done while full -> no overflow, word accepted.
- Switch mode 010->100 while 2 words are queued -> both remaining words use the substitute transform; words received after the drain are inverted; fake_select stays 1.
- Assert rst during WAIT_DONE with 3 words queued -> all outputs 0 asynchronously; after release FIFO empty, no stray start pulse.

Source files
------------

// File: rtl/mitm_inject_sequencer.sv
// mitm_inject_sequencer: one direction of the MITM fake bus path. Received words are
// transformed by the latched mode, queued, and replayed through the fake transmitter.
module mitm_inject_sequencer #(
   parameter int unsigned              NUM_DATA_BITS  = 8,
   parameter int unsigned              NUM_MITM_MODES = 3,
   parameter int unsigned              FIFO_DEPTH     = 4,
   parameter logic [NUM_DATA_BITS-1:0] MATCH_VALUE    = 8'h55,
   parameter logic [NUM_DATA_BITS-1:0] REPLACE_VALUE  = 8'hAA
) (
   input  logic                      sys_clk,
   input  logic                      rst,
   input  logic [NUM_MITM_MODES-1:0] mode_select,
   input  logic                      recv_new_data,
   input  logic [NUM_DATA_BITS-1:0]  real_recv_data,
   input  logic                      fake_send_ready,
   input  logic                      fake_send_done,
   output logic                      fake_select,
   output logic                      fake_send_start,
   output logic                      fake_keep_alive,
   output logic [NUM_DATA_BITS-1:0]  fake_send_data,
   output logic                      overflow
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [NUM_MITM_MODES-1:0] SEL_SUB = NUM_MITM_MODES'(2);
   localparam logic [NUM_MITM_MODES-1:0] SEL_INV = NUM_MITM_MODES'(4);

   typedef enum logic [1:0] {MODE_PASS = 2'd0, MODE_SUB = 2'd1, MODE_INV = 2'd2} mode_t;
   typedef enum logic {ST_IDLE = 1'b0, ST_WAIT_DONE = 1'b1} state_t;

   state_t                   r_state, w_state_next;
   mode_t                    r_active_mode, w_mode_req;
   logic [NUM_DATA_BITS-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]         r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0]         r_count, w_count_next;
   logic [NUM_DATA_BITS-1:0] r_send_data, w_xform_data;
   logic                     r_fake_select, r_send_start, r_keep_alive, r_overflow;
   logic                     w_empty, w_full, w_push_req, w_push, w_drop, w_launch, w_pop;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_mode_req = MODE_PASS;
      if (mode_select == SEL_SUB)      w_mode_req = MODE_SUB;
      else if (mode_select == SEL_INV) w_mode_req = MODE_INV;
   end

   always_comb begin
      w_xform_data = real_recv_data;
      case (r_active_mode)
         MODE_SUB: if (real_recv_data == MATCH_VALUE) w_xform_data = REPLACE_VALUE;
         MODE_INV: w_xform_data = ~real_recv_data;
         default:  w_xform_data = real_recv_data;
      endcase
   end

   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_push_req = recv_new_data && (r_active_mode != MODE_PASS);

   always_comb begin
      w_state_next = r_state;
      w_launch     = 1'b0;
      w_pop        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty && fake_send_ready) begin
               w_launch     = 1'b1;
               w_state_next = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (fake_send_done) begin
               w_pop        = 1'b1;
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // A pop in the same cycle frees the slot, so a push while full is still accepted.
   assign w_push       = w_push_req && (!w_full || w_pop);
   assign w_drop       = w_push_req && w_full && !w_pop;
   assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

   // NOTE: storage array has no reset; occupancy and pointers alone decide what is valid.
   always_ff @(posedge sys_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_xform_data;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= w_count_next;
      end
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   // The mode only changes between bursts, so queued words keep the transform they got.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         r_active_mode <= MODE_PASS;
         r_fake_select <= 1'b0;
      end else begin
         if ((r_state == ST_IDLE) && w_empty) r_active_mode <= w_mode_req;
         r_fake_select <= (r_active_mode != MODE_PASS);
      end
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         r_send_start <= 1'b0;
         r_send_data  <= '0;
         r_keep_alive <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_send_start <= w_launch;
         r_overflow   <= w_drop;
         if (w_launch) r_send_data <= r_mem[r_rd_ptr];
         // Keep-alive spans the whole burst and drops only once the queue has drained.
         if (w_launch)                         r_keep_alive <= 1'b1;
         else if (w_pop && w_count_next == '0) r_keep_alive <= 1'b0;
      end
   end

   assign fake_select     = r_fake_select;
   assign fake_send_start = r_send_start;
   assign fake_keep_alive = r_keep_alive;
   assign fake_send_data  = r_send_data;
   assign overflow        = r_overflow;

endmodule

// File: tb/tb_mitm_inject_sequencer.sv
// tb_mitm_inject_sequencer: table vectors, directed multi-cycle sequences and a
// randomized run checked against a queue-based scoreboard of the sequencer.
module tb_mitm_inject_sequencer;

   logic       sys_clk;
   logic       rst;
   logic [2:0] mode_select;
   logic       recv_new_data;
   logic [7:0] real_recv_data;
   logic       fake_send_ready;
   logic       fake_send_done;
   logic       fake_select;
   logic       fake_send_start;
   logic       fake_keep_alive;
   logic [7:0] fake_send_data;
   logic       overflow;

   int n_tests = 0;
   int n_fail  = 0;

   mitm_inject_sequencer dut (
      .sys_clk         (sys_clk),
      .rst             (rst),
      .mode_select     (mode_select),
      .recv_new_data   (recv_new_data),
      .real_recv_data  (real_recv_data),
      .fake_send_ready (fake_send_ready),
      .fake_send_done  (fake_send_done),
      .fake_select     (fake_select),
      .fake_send_start (fake_send_start),
      .fake_keep_alive (fake_keep_alive),
      .fake_send_data  (fake_send_data),
      .overflow        (overflow)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic [2:0] ms;
      logic [7:0] rx;
      logic       exp_sel;
      logic       exp_start;
      logic [7:0] exp_data;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Outputs are sampled and inputs driven 1 time unit after the active edge.
   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic reset_dut();
      rst             = 1'b1;
      recv_new_data   = 1'b0;
      real_recv_data  = 8'h00;
      fake_send_ready = 1'b0;
      fake_send_done  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic push_word(input logic [7:0] d);
      recv_new_data  = 1'b1;
      real_recv_data = d;
      tick();
      recv_new_data  = 1'b0;
   endtask

   // Waits (bounded) for a start pulse, checks the word, then returns done.
   task automatic serve_word(input string name, input logic [7:0] exp);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 12 && !seen; c++) begin
         if (fake_send_start) seen = 1'b1;
         else tick();
      end
      check({name, "_start_seen"}, 32'(seen), 1);
      check({name, "_data"}, 32'(fake_send_data), 32'(exp));
      tick();
      check({name, "_single_pulse"}, 32'(fake_send_start), 0);
      tick();
      check({name, "_data_hold"}, 32'(fake_send_data), 32'(exp));
      fake_send_done = 1'b1;
      tick();
      fake_send_done = 1'b0;
   endtask

   function automatic int decode(input logic [2:0] ms);
      case (ms)
         3'b010:  return 1;
         3'b100:  return 2;
         default: return 0;
      endcase
   endfunction

   function automatic logic [7:0] xform(input int mode, input logic [7:0] d);
      if (mode == 1) return (d == 8'h55) ? 8'hAA : d;
      if (mode == 2) return ~d;
      return d;
   endfunction

   task automatic run_random(input int n_cycles, input int n_drain);
      logic [7:0] sb[$];
      logic [7:0] pool [6];
      logic [7:0] hold, junk;
      bit         busy, exp_ovf, exp_keep, pop, push_req, drop, stim;
      int         done_at, mode, mode_d, new_mode;
      pool = '{8'd1, 8'd2, 8'd4, 8'd3, 8'd0, 8'd7};
      busy = 0; exp_ovf = 0; exp_keep = 0; done_at = 0; mode = 0; mode_d = 0; hold = 8'h00;
      for (int k = 0; k < n_cycles + n_drain; k++) begin
         check($sformatf("rand_c%0d_overflow", k), 32'(overflow), 32'(exp_ovf));
         check($sformatf("rand_c%0d_select", k), 32'(fake_select), 32'(mode_d != 0));
         if (fake_send_start) begin
            check($sformatf("rand_c%0d_start_while_busy", k), 32'(busy), 0);
            check($sformatf("rand_c%0d_word", k), 32'(fake_send_data),
                  (sb.size() != 0) ? 32'(sb[0]) : 32'hxxxx_xxxx);
            busy     = 1'b1;
            exp_keep = 1'b1;
            hold     = fake_send_data;
            done_at  = k + int'($urandom_range(1, 4));
         end
         check($sformatf("rand_c%0d_keep_alive", k), 32'(fake_keep_alive), 32'(exp_keep));
         if (busy) check($sformatf("rand_c%0d_data_hold", k), 32'(fake_send_data), 32'(hold));

         stim            = (k < n_cycles);
         recv_new_data   = stim && ($urandom_range(0, 9) < 4);
         real_recv_data  = 8'($urandom);
         fake_send_ready = stim ? ($urandom_range(0, 3) != 0) : 1'b1;
         fake_send_done  = busy ? (k == done_at) : ($urandom_range(0, 19) == 0);
         if (stim && $urandom_range(0, 49) == 0) mode_select = 3'(pool[$urandom_range(0, 5)]);

         pop      = busy && fake_send_done;
         push_req = recv_new_data && (mode != 0);
         drop     = push_req && (sb.size() == 4) && !pop;
         new_mode = (!busy && sb.size() == 0) ? decode(mode_select) : mode;
         if (pop) begin
            junk = sb.pop_front();
            busy = 1'b0;
         end
         if (push_req && !drop) sb.push_back(xform(mode, real_recv_data));
         if (pop && sb.size() == 0) exp_keep = 1'b0;
         exp_ovf = drop;
         mode_d  = mode;
         mode    = new_mode;
         tick();
      end
      check("rand_final_queue_empty", sb.size(), 0);
      check("rand_final_idle", 32'(busy), 0);
      check("rand_final_keep_alive", 32'(fake_keep_alive), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [9];
      bit   seen;
      int   ka_drops, extra, unstable;

      vecs[0] = '{3'b001, 8'h3C, 1'b0, 1'b0, 8'h00};
      vecs[1] = '{3'b010, 8'h55, 1'b1, 1'b1, 8'hAA};
      vecs[2] = '{3'b010, 8'h12, 1'b1, 1'b1, 8'h12};
      vecs[3] = '{3'b010, 8'hAA, 1'b1, 1'b1, 8'hAA};
      vecs[4] = '{3'b100, 8'h0F, 1'b1, 1'b1, 8'hF0};
      vecs[5] = '{3'b100, 8'hA5, 1'b1, 1'b1, 8'h5A};
      vecs[6] = '{3'b011, 8'h77, 1'b0, 1'b0, 8'h00};
      vecs[7] = '{3'b000, 8'h77, 1'b0, 1'b0, 8'h00};
      vecs[8] = '{3'b111, 8'h81, 1'b0, 1'b0, 8'h00};

      rst = 1'b1; mode_select = 3'b001; recv_new_data = 1'b0; real_recv_data = 8'h00;
      fake_send_ready = 1'b0; fake_send_done = 1'b0;
      reset_dut();
      check("reset_select", 32'(fake_select), 0);
      check("reset_start", 32'(fake_send_start), 0);
      check("reset_keep_alive", 32'(fake_keep_alive), 0);
      check("reset_data", 32'(fake_send_data), 0);
      check("reset_overflow", 32'(overflow), 0);

      for (int i = 0; i < 9; i++) begin
         reset_dut();
         mode_select     = vecs[i].ms;
         fake_send_ready = 1'b1;
         repeat (3) tick();
         check($sformatf("vec%0d_select", i), 32'(fake_select), 32'(vecs[i].exp_sel));
         push_word(vecs[i].rx);
         seen = 1'b0;
         for (int c = 0; c < 6 && !seen; c++) begin
            if (fake_send_start) seen = 1'b1;
            else tick();
         end
         check($sformatf("vec%0d_start", i), 32'(seen), 32'(vecs[i].exp_start));
         check($sformatf("vec%0d_data", i), 32'(fake_send_data), 32'(vecs[i].exp_data));
         if (seen) begin
            tick();
            check($sformatf("vec%0d_one_pulse", i), 32'(fake_send_start), 0);
            fake_send_done = 1'b1;
            tick();
            fake_send_done = 1'b0;
            check($sformatf("vec%0d_keep_drop", i), 32'(fake_keep_alive), 0);
         end
      end

      // Substitute mode: exact start latency and one keep-alive span over two words.
      reset_dut();
      mode_select = 3'b010; fake_send_ready = 1'b1;
      repeat (3) tick();
      recv_new_data = 1'b1; real_recv_data = 8'h55;
      tick();
      real_recv_data = 8'h12;
      check("lat_n1_no_start", 32'(fake_send_start), 0);
      tick();
      recv_new_data = 1'b0;
      check("lat_n2_start", 32'(fake_send_start), 1);
      check("lat_word0", 32'(fake_send_data), 32'hAA);
      check("lat_keep_at_start", 32'(fake_keep_alive), 1);
      ka_drops = 0; extra = 0; unstable = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (!fake_keep_alive) ka_drops++;
         if (fake_send_start) extra++;
         if (fake_send_data !== 8'hAA) unstable++;
      end
      fake_send_done = 1'b1;
      tick();
      fake_send_done = 1'b0;
      check("burst_keep_between", 32'(fake_keep_alive), 1);
      check("burst_no_early_start", 32'(fake_send_start), 0);
      tick();
      check("burst_start2", 32'(fake_send_start), 1);
      check("burst_word1", 32'(fake_send_data), 32'h12);
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (!fake_keep_alive) ka_drops++;
         if (fake_send_start) extra++;
         if (fake_send_data !== 8'h12) unstable++;
      end
      fake_send_done = 1'b1;
      tick();
      fake_send_done = 1'b0;
      check("burst_keep_drop", 32'(fake_keep_alive), 0);
      check("burst_keep_drops", ka_drops, 0);
      check("burst_extra_starts", extra, 0);
      check("burst_data_unstable", unstable, 0);

      // Overflow with done held low, then push on the done cycle while full.
      reset_dut();
      mode_select = 3'b010; fake_send_ready = 1'b1;
      repeat (3) tick();
      for (int i = 0; i < 6; i++) begin
         push_word(8'h10 + 8'(i));
         check($sformatf("ovf_push%0d", i), 32'(overflow), 32'(i >= 4));
      end
      tick();
      check("ovf_single_pulse", 32'(overflow), 0);
      check("ovf_word0", 32'(fake_send_data), 32'h10);
      fake_send_done = 1'b1; recv_new_data = 1'b1; real_recv_data = 8'hC3;
      tick();
      fake_send_done = 1'b0; recv_new_data = 1'b0;
      check("full_push_pop_no_ovf", 32'(overflow), 0);
      serve_word("ovf_word1", 8'h11);
      serve_word("ovf_word2", 8'h12);
      serve_word("ovf_word3", 8'h13);
      serve_word("ovf_word_c3", 8'hC3);
      check("ovf_drain_keep", 32'(fake_keep_alive), 0);

      // Mode switch requested while words are still queued.
      reset_dut();
      mode_select = 3'b010;
      repeat (3) tick();
      push_word(8'h55);
      push_word(8'h12);
      mode_select = 3'b100;
      push_word(8'h0F);
      fake_send_ready = 1'b1;
      serve_word("sw_word0", 8'hAA);
      serve_word("sw_word1", 8'h12);
      serve_word("sw_word2", 8'h0F);
      check("sw_select_mid", 32'(fake_select), 1);
      repeat (3) tick();
      push_word(8'h0F);
      serve_word("sw_inverted", 8'hF0);
      check("sw_select_after", 32'(fake_select), 1);

      // Asynchronous reset in the middle of a burst.
      reset_dut();
      mode_select = 3'b010;
      repeat (3) tick();
      push_word(8'h21);
      push_word(8'h22);
      push_word(8'h23);
      fake_send_ready = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 8 && !seen; c++) begin
         if (fake_send_start) seen = 1'b1;
         else tick();
      end
      check("rst_mid_started", 32'(seen), 1);
      tick();
      check("rst_mid_keep_before", 32'(fake_keep_alive), 1);
      rst = 1'b1;
      #2;
      check("rst_async_select", 32'(fake_select), 0);
      check("rst_async_start", 32'(fake_send_start), 0);
      check("rst_async_keep", 32'(fake_keep_alive), 0);
      check("rst_async_data", 32'(fake_send_data), 0);
      check("rst_async_overflow", 32'(overflow), 0);
      tick();
      tick();
      rst = 1'b0;
      extra = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (fake_send_start) extra++;
      end
      check("rst_no_stray_start", extra, 0);
      check("rst_select_back", 32'(fake_select), 1);
      push_word(8'h0F);
      serve_word("rst_fresh_word", 8'h0F);

      reset_dut();
      run_random(3000, 60);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
